// File: rtl/core_pc_pkg.sv
// Shared definitions for the multithreaded PC generator: BTB prediction
// type encodings and the default reset address for thread 0.
package core_pc_pkg;

    typedef enum logic [1:0] {
        BTB_BR  = 2'b00,
        BTB_J   = 2'b01,
        BTB_JAL = 2'b10,
        BTB_JR  = 2'b11
    } btb_type_e;

    localparam logic [31:0] RESET_ADDR_DEF = 32'h0004_0000;
    localparam logic [31:0] THR_STRIDE_DEF = 32'h0000_1000;

endpackage

// File: rtl/core_pc_rr_arb.sv
// Round-robin thread selector: grants the first set bit of mask searching
// upward from last+1, wrapping modulo N_THR. Purely combinational.
module core_pc_rr_arb #(
    parameter int N_THR = 4,
    parameter int TW    = $clog2(N_THR)
) (
    input  logic [N_THR-1:0] mask,
    input  logic [TW-1:0]    last,
    output logic [TW-1:0]    grant,
    output logic             any
);

    logic found_s;
    int   idx_s;

    // Scan threads in rotating priority order, last-issued thread checked last.
    always_comb begin
        found_s = 1'b0;
        grant   = '0;
        idx_s   = 0;
        for (int i = 1; i <= N_THR; i++) begin
            idx_s = (int'(last) + i) % N_THR;
            if (!found_s && mask[idx_s]) begin
                found_s = 1'b1;
                grant   = TW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/core_pc_mt.sv
// Multithreaded fetch PC generator: one PC per hardware thread, round-robin
// offer to fetch, BTB/RAS-steered next-PC on issue, decode redirects win.
module core_pc_mt
    import core_pc_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              N_THR      = 4,
    parameter int              TW         = $clog2(N_THR),
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
    parameter logic [ADDR_W-1:0] THR_STRIDE = ADDR_W'(THR_STRIDE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_THR-1:0]  thr_en,
    input  logic              stall,
    input  logic              pc_ready,
    input  logic              redir_v,
    input  logic [TW-1:0]     redir_thr,
    input  logic [ADDR_W-1:0] redir_target,
    input  logic              btb_v,
    input  logic [1:0]        btb_type,
    input  logic [ADDR_W-1:0] btb_target,
    input  logic [ADDR_W-1:0] ras_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [TW-1:0]     pc_thr,
    output logic              v_pc_out,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] pc_r [N_THR];
    logic [TW-1:0]     last_thr_r;
    logic [TW-1:0]     sel_thr_s;
    logic              any_s;
    logic              issue_s;
    logic              redir_ok_s;
    logic [ADDR_W-1:0] issue_pc_s;

    core_pc_rr_arb #(
        .N_THR (N_THR),
        .TW    (TW)
    ) u_arb (
        .mask  (thr_en),
        .last  (last_thr_r),
        .grant (sel_thr_s),
        .any   (any_s)
    );

    assign pc_thr     = sel_thr_s;
    assign pc_out     = pc_r[sel_thr_s];
    assign pc_plus4   = pc_out + ADDR_W'(4);
    assign v_pc_out   = any_s && !stall;
    assign issue_s    = v_pc_out && pc_ready;
    // A stalled pipeline drops redirects; the sender keeps redir_v held.
    assign redir_ok_s = redir_v && !stall;

    // Choose the successor PC for the thread being issued from the prediction.
    always_comb begin
        issue_pc_s = pc_plus4;
        if (btb_v) begin
            case (btb_type_e'(btb_type))
                BTB_BR, BTB_J, BTB_JAL: issue_pc_s = btb_target;
                BTB_JR:                 issue_pc_s = ras_target;
                default:                issue_pc_s = pc_plus4;
            endcase
        end else begin
            issue_pc_s = pc_plus4;
        end
    end

    // Last-issued pointer advances only on a completed handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_thr_r <= TW'(N_THR - 1);
        end else if (issue_s) begin
            last_thr_r <= sel_thr_s;
        end else begin
            last_thr_r <= last_thr_r;
        end
    end

    for (genvar g = 0; g < N_THR; g++) begin : g_thr
        localparam logic [ADDR_W-1:0] RST_PC = RESET_ADDR + ADDR_W'(g) * THR_STRIDE;
        // Per-thread PC: redirect beats the issue update; a redir_thr that
        // matches no thread index simply updates nothing.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pc_r[g] <= RST_PC;
            end else if (redir_ok_s && (redir_thr == TW'(g))) begin
                pc_r[g] <= redir_target;
            end else if (issue_s && (sel_thr_s == TW'(g))) begin
                pc_r[g] <= issue_pc_s;
            end else begin
                pc_r[g] <= pc_r[g];
            end
        end
    end

endmodule

// File: tb/tb_core_pc_mt.sv
// Directed, table-driven bench for core_pc_mt (default parameters).
module tb_core_pc_mt;

    localparam logic [1:0] T_BR  = 2'b00;
    localparam logic [1:0] T_J   = 2'b01;
    localparam logic [1:0] T_JAL = 2'b10;
    localparam logic [1:0] T_JR  = 2'b11;

    logic        clk;
    logic        rst;
    logic [3:0]  thr_en;
    logic        stall;
    logic        pc_ready;
    logic        redir_v;
    logic [1:0]  redir_thr;
    logic [31:0] redir_target;
    logic        btb_v;
    logic [1:0]  btb_type;
    logic [31:0] btb_target;
    logic [31:0] ras_target;
    logic [31:0] pc_out;
    logic [1:0]  pc_thr;
    logic        v_pc_out;
    logic [31:0] pc_plus4;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  en;
        logic        rdy;
        logic        stl;
        logic        bv;
        logic [1:0]  bt;
        logic [31:0] btgt;
        logic [31:0] ras;
        logic        rv;
        logic [1:0]  rthr;
        logic [31:0] rtgt;
        logic        ev;
        logic [1:0]  ethr;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    core_pc_mt dut (
        .clk          (clk),
        .rst          (rst),
        .thr_en       (thr_en),
        .stall        (stall),
        .pc_ready     (pc_ready),
        .redir_v      (redir_v),
        .redir_thr    (redir_thr),
        .redir_target (redir_target),
        .btb_v        (btb_v),
        .btb_type     (btb_type),
        .btb_target   (btb_target),
        .ras_target   (ras_target),
        .pc_out       (pc_out),
        .pc_thr       (pc_thr),
        .v_pc_out     (v_pc_out),
        .pc_plus4     (pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Plain vector: optional prediction, no redirect, no stall.
    task automatic add(input logic [3:0] en, input logic rdy, input logic bv, input logic [1:0] bt,
                       input logic [31:0] btgt, input logic [31:0] ras,
                       input logic ev, input logic [1:0] ethr, input logic [31:0] epc);
        vec_t v;
        v = '{en, rdy, 1'b0, bv, bt, btgt, ras, 1'b0, 2'd0, 32'd0, ev, ethr, epc};
        vecs.push_back(v);
    endtask

    // Vector carrying a redirect and/or stall.
    task automatic add_r(input logic [3:0] en, input logic rdy, input logic stl,
                         input logic rv, input logic [1:0] rthr, input logic [31:0] rtgt,
                         input logic ev, input logic [1:0] ethr, input logic [31:0] epc);
        vec_t v;
        v = '{en, rdy, stl, 1'b0, T_BR, 32'd0, 32'd0, rv, rthr, rtgt, ev, ethr, epc};
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        thr_en = 4'b0000; stall = 1'b0; pc_ready = 1'b0; redir_v = 1'b0;
        redir_thr = 2'd0; redir_target = 32'd0; btb_v = 1'b0; btb_type = T_BR;
        btb_target = 32'd0; ras_target = 32'd0;
    endtask

    task automatic check_offer(input string name, input logic [1:0] ethr, input logic [31:0] epc);
        check({name, ".v"},   {31'd0, v_pc_out}, 32'd1);
        check({name, ".thr"}, {30'd0, pc_thr},   {30'd0, ethr});
        check({name, ".pc"},  pc_out,            epc);
        check({name, ".p4"},  pc_plus4,          epc + 32'd4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b1;

        // Round robin over all four threads from reset.
        add(4'b1111, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd0, 32'h0004_0000);
        add(4'b1111, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd1, 32'h0004_1000);
        add(4'b1111, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd2, 32'h0004_2000);
        add(4'b1111, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd3, 32'h0004_3000);
        add(4'b1111, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd0, 32'h0004_0004);
        add(4'b1111, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd1, 32'h0004_1004);
        // Sparse mask 0101 with pc_ready toggling; offer holds while not ready.
        add(4'b0101, 1'b0, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd2, 32'h0004_2004);
        add(4'b0101, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd2, 32'h0004_2004);
        add(4'b0101, 1'b0, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd0, 32'h0004_0008);
        add(4'b0101, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd0, 32'h0004_0008);
        add(4'b0101, 1'b1, 1'b0, T_BR, 32'd0, 32'd0, 1'b1, 2'd2, 32'h0004_2008);
        // Predictions on thread 1: JR, J, BR, JAL, and btb_v=0 ignores type.
        add(4'b0010, 1'b1, 1'b1, T_JR,  32'h0000_DEAD, 32'h0000_5000, 1'b1, 2'd1, 32'h0004_1008);
        add(4'b0010, 1'b1, 1'b1, T_J,   32'h0000_6000, 32'h0000_BEEF, 1'b1, 2'd1, 32'h0000_5000);
        add(4'b0010, 1'b1, 1'b1, T_BR,  32'h0000_8000, 32'h0000_BEEF, 1'b1, 2'd1, 32'h0000_6000);
        add(4'b0010, 1'b1, 1'b1, T_JAL, 32'h0000_9000, 32'h0000_BEEF, 1'b1, 2'd1, 32'h0000_8000);
        add(4'b0010, 1'b1, 1'b0, T_J,   32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 2'd1, 32'h0000_9000);
        add(4'b0010, 1'b0, 1'b0, T_BR,  32'd0, 32'd0, 1'b1, 2'd1, 32'h0000_9004);
        // Redirect colliding with issue of thread 2; last_thr still moves to 2.
        add_r(4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 32'h0000_7000, 1'b1, 2'd2, 32'h0004_200C);
        add_r(4'b0100, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd2, 32'h0000_7000);
        add_r(4'b0101, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd0, 32'h0004_000C);
        // Stall with redirect and ready: nothing may change.
        add_r(4'b1111, 1'b1, 1'b1, 1'b1, 2'd0, 32'h0000_AAAA, 1'b0, 2'd0, 32'd0);
        add_r(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd3, 32'h0004_3004);
        add_r(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd0, 32'h0004_000C);
        // Redirect into a disabled thread while another issues.
        add_r(4'b0001, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0000_1234, 1'b1, 2'd0, 32'h0004_000C);
        add_r(4'b1000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd3, 32'h0000_1234);
        // No thread enabled: never valid, redirect still lands.
        add_r(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0,        1'b0, 2'd0, 32'd0);
        add_r(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 32'h0000_B000, 1'b0, 2'd0, 32'd0);
        add_r(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd1, 32'h0000_B000);
        // Address wrap on thread 0.
        add_r(4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFC, 1'b0, 2'd0, 32'd0);
        add_r(4'b0001, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd0, 32'hFFFF_FFFC);
        add_r(4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0,        1'b1, 2'd0, 32'h0000_0000);

        // Outputs are live during reset.
        @(negedge clk);
        thr_en = 4'b1111;
        #1;
        check_offer("rst_hold", 2'd0, 32'h0004_0000);
        thr_en = 4'b0100;
        #1;
        check_offer("rst_hold_t2", 2'd2, 32'h0004_2000);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            thr_en = vecs[k].en; pc_ready = vecs[k].rdy; stall = vecs[k].stl;
            btb_v = vecs[k].bv; btb_type = vecs[k].bt; btb_target = vecs[k].btgt;
            ras_target = vecs[k].ras; redir_v = vecs[k].rv; redir_thr = vecs[k].rthr;
            redir_target = vecs[k].rtgt;
            #1;
            check($sformatf("vec%0d.v", k), {31'd0, v_pc_out}, {31'd0, vecs[k].ev});
            if (vecs[k].ev) begin
                check($sformatf("vec%0d.thr", k), {30'd0, pc_thr}, {30'd0, vecs[k].ethr});
                check($sformatf("vec%0d.pc", k), pc_out, vecs[k].epc);
                check($sformatf("vec%0d.p4", k), pc_plus4, vecs[k].epc + 32'd4);
            end
        end

        // Burst, then asynchronous reset between clock edges.
        @(negedge clk);
        idle_inputs();
        thr_en = 4'b1111; pc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_offer("async_rst", 2'd0, 32'h0004_0000);
        thr_en = 4'b0010;
        #1;
        check_offer("async_rst_t1", 2'd1, 32'h0004_1000);
        thr_en = 4'b1000;
        #1;
        check_offer("async_rst_t3", 2'd3, 32'h0004_3000);
        @(negedge clk);
        rst = 1'b0;
        thr_en = 4'b1111;
        #1;
        check_offer("post_rst0", 2'd0, 32'h0004_0000);
        @(negedge clk);
        #1;
        check_offer("post_rst1", 2'd1, 32'h0004_1000);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
